// File: rtl/mc_maindec_if.sv
// mc_maindec_if -- control bundle between the multicycle main decoder and the datapath.
//
// Optional feature macro: MC_MAINDEC_BNE_EN adds the bne control.
//
// Signals
//   op[5:0]        opcode from the instruction register      (datapath -> decoder)
//   mem_ready      memory finishes its access this cycle      (datapath -> decoder)
//   memwrite, lord, irwrite, pcwrite, branch, regwrite,
//   memtoreg, regdst, alusrca                                 (decoder -> datapath)
//   alusrcb[1:0], pcsrc[1:0], aluop[1:0]                      (decoder -> datapath)
//   illegal_op, mem_err   one-cycle status pulses             (decoder -> datapath)
//   bne            branch-if-not-equal strobe, macro builds only
//
// Modports
//   master : the decoder, which drives every control
//   slave  : the datapath / controller side that consumes them
interface mc_maindec_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       memwrite;
    logic       lord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic       mem_err;
`ifdef MC_MAINDEC_BNE_EN
    logic       bne;

    modport master (
        input  op, mem_ready,
        output memwrite, lord, irwrite, pcwrite, branch, regwrite, memtoreg,
               regdst, alusrca, alusrcb, pcsrc, aluop, illegal_op, mem_err, bne
    );
    modport slave (
        output op, mem_ready,
        input  memwrite, lord, irwrite, pcwrite, branch, regwrite, memtoreg,
               regdst, alusrca, alusrcb, pcsrc, aluop, illegal_op, mem_err, bne
    );
`else
    modport master (
        input  op, mem_ready,
        output memwrite, lord, irwrite, pcwrite, branch, regwrite, memtoreg,
               regdst, alusrca, alusrcb, pcsrc, aluop, illegal_op, mem_err
    );
    modport slave (
        output op, mem_ready,
        input  memwrite, lord, irwrite, pcwrite, branch, regwrite, memtoreg,
               regdst, alusrca, alusrcb, pcsrc, aluop, illegal_op, mem_err
    );
`endif
endinterface

// File: rtl/mc_maindec.sv
// mc_maindec -- multicycle MIPS main control FSM.
//
// Decodes the opcode over several cycles and drives the datapath enables and
// mux selects. aluop goes to the ALU decoder: 00 add, 01 sub, 10 funct, 11 or.
// Memory stalls are taken via mem_ready; a wait that reaches MEM_TIMEOUT
// cycles is abandoned (back to FETCH, mem_err pulse).
//
// Optional feature macro: MC_MAINDEC_BNE_EN (adds BNEEX state and bus.bne).
//
// Parameters
//   MEM_TIMEOUT  max consecutive wait cycles before abort, 0 = never abort
//   TO_W         wait-counter width, 2**TO_W > MEM_TIMEOUT
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    mc_maindec_if.master (opcode/mem_ready in, controls and status out)
module mc_maindec #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic          clk,
    input  logic          reset,
    mc_maindec_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
        BEQEX, ADDIEX, ORIEX, IMMWB, JEX, BNEEX
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    state_t          state, state_next;
    logic [TO_W-1:0] wait_cnt;
    logic            waiting;
    logic            abort;
    logic            illegal_d;
    logic            illegal_q;
    logic            mem_err_q;

    // A memory-wait state with memory not yet done; abort when the wait has
    // already lasted MEM_TIMEOUT cycles.
    assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !bus.mem_ready;
    assign abort   = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TO_LIM);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        illegal_d  = 1'b0;
        case (state)
            FETCH:   if (bus.mem_ready) state_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_ORI:       state_next = ORIEX;
                    OP_J:         state_next = JEX;
`ifdef MC_MAINDEC_BNE_EN
                    OP_BNE:       state_next = BNEEX;
`endif
                    default: begin
                        state_next = FETCH;
                        illegal_d  = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (bus.mem_ready) state_next = MEMWB;
            MEMWR:   if (bus.mem_ready) state_next = FETCH;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = IMMWB;
            ORIEX:   state_next = IMMWB;
            default: state_next = FETCH;
        endcase
        if (abort) state_next = FETCH;
    end

    // Wait counter and status pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            mem_err_q <= abort;
            // FETCH->FETCH on abort is not a state change, so clear explicitly.
            if (abort || state_next != state) wait_cnt <= '0;
            else if (waiting)                 wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    assign bus.illegal_op = illegal_q;
    assign bus.mem_err    = mem_err_q;

    // Output logic: Moore from state, plus mem_ready-gated fetch writes and
    // the memwrite hold-off in an aborted MEMWR cycle.
    always_comb begin
        bus.memwrite = 1'b0;
        bus.lord     = 1'b0;
        bus.irwrite  = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.branch   = 1'b0;
        bus.regwrite = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        bus.aluop    = 2'b00;
`ifdef MC_MAINDEC_BNE_EN
        bus.bne      = 1'b0;
`endif
        case (state)
            FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            DECODE:  bus.alusrcb = 2'b11;
            MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            MEMRD:   bus.lord = 1'b1;
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            MEMWR: begin
                bus.lord     = 1'b1;
                bus.memwrite = !abort;
            end
            RTYPEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
            end
            RTYPEWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            BEQEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.branch  = 1'b1;
                bus.pcsrc   = 2'b01;
            end
            ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
            end
            ORIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b11;
            end
            IMMWB:   bus.regwrite = 1'b1;
            JEX: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
`ifdef MC_MAINDEC_BNE_EN
            BNEEX: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 2'b01;
                bus.bne     = 1'b1;
            end
`endif
            default: ;
        endcase
        // Reset low abandons whatever is in flight: no write may escape.
        if (!reset) begin
            bus.memwrite = 1'b0;
            bus.irwrite  = 1'b0;
            bus.pcwrite  = 1'b0;
            bus.branch   = 1'b0;
            bus.regwrite = 1'b0;
`ifdef MC_MAINDEC_BNE_EN
            bus.bne      = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec -- scoreboard bench for mc_maindec.
// Two instances share the stimulus: dut_a (default MEM_TIMEOUT=15) and
// dut_b (MEM_TIMEOUT=2) for the timeout cases.
module tb_mc_maindec;
    typedef struct packed {
        logic       memwrite, lord, irwrite, pcwrite, branch, regwrite, memtoreg, regdst, alusrca;
        logic [1:0] alusrcb, pcsrc, aluop;
        logic       illegal_op, mem_err, bne;
    } ctl_t;

    typedef enum {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
                  S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ORIEX, S_IMMWB, S_JEX, S_BNEEX} tst_t;

    typedef struct {
        string tag;
        bit    sel;
        ctl_t  exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    int         n_tests = 0;
    int         n_fail = 0;
    sb_t        sb[$];
    ctl_t       ctl_a, ctl_b;

    mc_maindec_if ifa ();
    mc_maindec_if ifb ();

    assign ifa.op = op;
    assign ifa.mem_ready = mem_ready;
    assign ifb.op = op;
    assign ifb.mem_ready = mem_ready;

    mc_maindec dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mc_maindec #(.MEM_TIMEOUT(2), .TO_W(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

`ifdef MC_MAINDEC_BNE_EN
    assign ctl_a = {ifa.memwrite, ifa.lord, ifa.irwrite, ifa.pcwrite, ifa.branch, ifa.regwrite,
                    ifa.memtoreg, ifa.regdst, ifa.alusrca, ifa.alusrcb, ifa.pcsrc, ifa.aluop,
                    ifa.illegal_op, ifa.mem_err, ifa.bne};
    assign ctl_b = {ifb.memwrite, ifb.lord, ifb.irwrite, ifb.pcwrite, ifb.branch, ifb.regwrite,
                    ifb.memtoreg, ifb.regdst, ifb.alusrca, ifb.alusrcb, ifb.pcsrc, ifb.aluop,
                    ifb.illegal_op, ifb.mem_err, ifb.bne};
`else
    assign ctl_a = {ifa.memwrite, ifa.lord, ifa.irwrite, ifa.pcwrite, ifa.branch, ifa.regwrite,
                    ifa.memtoreg, ifa.regdst, ifa.alusrca, ifa.alusrcb, ifa.pcsrc, ifa.aluop,
                    ifa.illegal_op, ifa.mem_err, 1'b0};
    assign ctl_b = {ifb.memwrite, ifb.lord, ifb.irwrite, ifb.pcwrite, ifb.branch, ifb.regwrite,
                    ifb.memtoreg, ifb.regdst, ifb.alusrca, ifb.alusrcb, ifb.pcsrc, ifb.aluop,
                    ifb.illegal_op, ifb.mem_err, 1'b0};
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input ctl_t got, input ctl_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Expected control outputs of each state, straight from the control table.
    function automatic ctl_t st_out(input tst_t s, input bit mr);
        ctl_t c = '0;
        case (s)
            S_FETCH:   begin c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.lord = 1;
            S_MEMWB:   begin c.memtoreg = 1; c.regwrite = 1; end
            S_MEMWR:   begin c.lord = 1; c.memwrite = 1; end
            S_RTYPEEX: begin c.alusrca = 1; c.aluop = 2'b10; end
            S_RTYPEWB: begin c.regdst = 1; c.regwrite = 1; end
            S_BEQEX:   begin c.alusrca = 1; c.aluop = 2'b01; c.branch = 1; c.pcsrc = 2'b01; end
            S_ADDIEX:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            S_ORIEX:   begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 2'b11; end
            S_IMMWB:   c.regwrite = 1;
            S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1; end
            S_BNEEX:   begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.bne = 1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t ill(input ctl_t c);
        ctl_t r = c;
        r.illegal_op = 1'b1;
        return r;
    endfunction

    function automatic ctl_t merr(input ctl_t c);
        ctl_t r = c;
        r.mem_err = 1'b1;
        return r;
    endfunction

    // One cycle of stimulus with reset released; expectation queued for that cycle.
    task automatic step(input string tag, input logic [5:0] o, input bit mr,
                        input ctl_t e, input bit sel);
        @(posedge clk);
        #1;
        reset = 1'b1;
        op = o;
        mem_ready = mr;
        sb.push_back('{tag, sel, e});
    endtask

    // Two edges with reset low; the cycle after the first must be FETCH with writes held off.
    task automatic do_reset(input bit chk_first, input ctl_t first);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        if (chk_first) sb.push_back('{"rst_midinstr", 1'b0, first});
        @(posedge clk);
        #1;
        sb.push_back('{"rst_a", 1'b0, st_out(S_FETCH, 1'b0)});
        sb.push_back('{"rst_b", 1'b1, st_out(S_FETCH, 1'b0)});
    endtask

    // Scoreboard: compare everything queued for this cycle away from the active edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            check(e.tag, e.sel ? ctl_b : ctl_a, e.exp);
        end
    end

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           ADDI = 6'b001000, ORI = 6'b001101, J = 6'b000010, BNE = 6'b000101,
                           BAD = 6'b111111;

    initial begin
        do_reset(1'b0, '0);

        // fetch stall, then lw with memory always ready
        step("fetch_wait0", LW, 0, st_out(S_FETCH, 0), 0);
        step("fetch_wait1", LW, 0, st_out(S_FETCH, 0), 0);
        step("lw_fetch",  LW, 1, st_out(S_FETCH, 1), 0);
        step("lw_decode", LW, 1, st_out(S_DECODE, 1), 0);
        step("lw_memadr", LW, 1, st_out(S_MEMADR, 1), 0);
        step("lw_memrd",  LW, 1, st_out(S_MEMRD, 1), 0);
        step("lw_memwb",  LW, 1, st_out(S_MEMWB, 1), 0);

        step("ori_fetch",  ORI, 1, st_out(S_FETCH, 1), 0);
        step("ori_decode", ORI, 1, st_out(S_DECODE, 1), 0);
        step("ori_ex",     ORI, 1, st_out(S_ORIEX, 1), 0);
        step("ori_wb",     ORI, 1, st_out(S_IMMWB, 1), 0);

        step("r_fetch",  RT, 1, st_out(S_FETCH, 1), 0);
        step("r_decode", RT, 1, st_out(S_DECODE, 1), 0);
        step("r_ex",     RT, 1, st_out(S_RTYPEEX, 1), 0);
        step("r_wb",     RT, 1, st_out(S_RTYPEWB, 1), 0);

        step("addi_fetch",  ADDI, 1, st_out(S_FETCH, 1), 0);
        step("addi_decode", ADDI, 1, st_out(S_DECODE, 1), 0);
        step("addi_ex",     ADDI, 1, st_out(S_ADDIEX, 1), 0);
        step("addi_wb",     ADDI, 1, st_out(S_IMMWB, 1), 0);

        step("beq_fetch",  BEQ, 1, st_out(S_FETCH, 1), 0);
        step("beq_decode", BEQ, 1, st_out(S_DECODE, 1), 0);
        step("beq_ex",     BEQ, 1, st_out(S_BEQEX, 1), 0);

        step("j_fetch",  J, 1, st_out(S_FETCH, 1), 0);
        step("j_decode", J, 1, st_out(S_DECODE, 1), 0);
        step("j_ex",     J, 1, st_out(S_JEX, 1), 0);

        // sw with three stalled cycles: memwrite held four cycles, no error
        step("sw_fetch",  SW, 1, st_out(S_FETCH, 1), 0);
        step("sw_decode", SW, 1, st_out(S_DECODE, 1), 0);
        step("sw_memadr", SW, 1, st_out(S_MEMADR, 1), 0);
        for (int i = 0; i < 3; i++)
            step("sw_memwr_wait", SW, 0, st_out(S_MEMWR, 0), 0);
        step("sw_memwr_done", SW, 1, st_out(S_MEMWR, 1), 0);

        // illegal opcode: back to FETCH, one-cycle illegal_op pulse
        step("ill_fetch",  BAD, 1, st_out(S_FETCH, 1), 0);
        step("ill_decode", BAD, 1, st_out(S_DECODE, 1), 0);
        step("ill_pulse",  BAD, 0, ill(st_out(S_FETCH, 0)), 0);
        step("ill_clear",  BAD, 0, st_out(S_FETCH, 0), 0);

        step("bne_fetch",  BNE, 1, st_out(S_FETCH, 1), 0);
        step("bne_decode", BNE, 1, st_out(S_DECODE, 1), 0);
`ifdef MC_MAINDEC_BNE_EN
        step("bne_ex",     BNE, 1, st_out(S_BNEEX, 1), 0);
`else
        step("bne_illegal", BNE, 0, ill(st_out(S_FETCH, 0)), 0);
`endif

        // reset in the middle of a store: no memwrite in the reset cycle
        step("sw2_fetch",  SW, 1, st_out(S_FETCH, 1), 0);
        step("sw2_decode", SW, 1, st_out(S_DECODE, 1), 0);
        step("sw2_memadr", SW, 1, st_out(S_MEMADR, 1), 0);
        begin
            ctl_t e;
            e = st_out(S_MEMWR, 1);
            e.memwrite = 1'b0;
            do_reset(1'b1, e);
        end

        // dut_b, MEM_TIMEOUT=2: load timeout in MEMRD
        step("to_fetch",  LW, 1, st_out(S_FETCH, 1), 1);
        step("to_decode", LW, 1, st_out(S_DECODE, 1), 1);
        step("to_memadr", LW, 1, st_out(S_MEMADR, 1), 1);
        for (int i = 0; i < 3; i++)
            step("to_memrd", LW, 0, st_out(S_MEMRD, 0), 1);
        step("to_err_pulse", LW, 0, merr(st_out(S_FETCH, 0)), 1);
        // fetch timeout: FETCH->FETCH abort with no write
        step("to_fetch_w1", LW, 0, st_out(S_FETCH, 0), 1);
        step("to_fetch_w2", LW, 0, st_out(S_FETCH, 0), 1);
        step("to_fetch_err", SW, 1, merr(st_out(S_FETCH, 1)), 1);
        // ready arrives in the limit cycle: completes, no error
        step("lim_decode", SW, 1, st_out(S_DECODE, 1), 1);
        step("lim_memadr", SW, 1, st_out(S_MEMADR, 1), 1);
        step("lim_memwr0", SW, 0, st_out(S_MEMWR, 0), 1);
        step("lim_memwr1", SW, 0, st_out(S_MEMWR, 0), 1);
        step("lim_memwr2", SW, 1, st_out(S_MEMWR, 1), 1);
        step("lim_fetch",  SW, 1, st_out(S_FETCH, 1), 1);
        // store timeout: memwrite withheld in the abort cycle
        step("swto_decode", SW, 1, st_out(S_DECODE, 1), 1);
        step("swto_memadr", SW, 1, st_out(S_MEMADR, 1), 1);
        step("swto_memwr0", SW, 0, st_out(S_MEMWR, 0), 1);
        step("swto_memwr1", SW, 0, st_out(S_MEMWR, 0), 1);
        begin
            ctl_t e;
            e = st_out(S_MEMWR, 0);
            e.memwrite = 1'b0;
            step("swto_abort", SW, 0, e, 1);
        end
        step("swto_err", SW, 0, merr(st_out(S_FETCH, 0)), 1);

        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
